// File: rtl/popcount_seq_ctrl_pkg.sv
// Shared constants, FSM state type and chunk-count helper for the popcount sequencer.
package popcount_seq_ctrl_pkg;

  localparam int CHUNK_W = 11;
  localparam int SUM_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of 11-bit compressor passes needed for a vector of vec_w bits.
  function automatic int chunks_for(input int vec_w);
    return (vec_w + CHUNK_W - 1) / CHUNK_W;
  endfunction

endpackage

// File: rtl/adder_11to4.sv
// Combinational 11-input population-count compressor producing a 4-bit sum.
module adder_11to4
  import popcount_seq_ctrl_pkg::*;
(
  input  logic [CHUNK_W-1:0] bits,
  output logic [SUM_W-1:0]   sum
);

  // Ripple of single-bit increments; synthesis folds this into a compressor tree.
  always_comb begin
    sum = {SUM_W{1'b0}};
    for (int i = 0; i < CHUNK_W; i++) begin
      sum = sum + {{(SUM_W-1){1'b0}}, bits[i]};
    end
  end

endmodule

// File: rtl/popcount_seq_ctrl.sv
// Frame-level popcount sequencer: slices accepted XNOR beats into 11-bit chunks,
// accumulates a saturating count and reports it with a threshold activation bit.
module popcount_seq_ctrl
  import popcount_seq_ctrl_pkg::*;
#(
  parameter int VEC_W = 99,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_data,
  input  logic             in_last,
  input  logic [ACC_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_bit,
  output logic             out_sat,
  output logic             busy
);

  localparam int CHUNKS = chunks_for(VEC_W);
  localparam int PAD_W  = CHUNKS * CHUNK_W;
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

  state_t             state, state_next;
  logic [PAD_W-1:0]   beat;
  logic               last_q;
  logic [IDX_W-1:0]   chunk_idx;
  logic [ACC_W-1:0]   acc;
  logic               sat;
  logic               first;
  logic [ACC_W-1:0]   thresh_q;
  logic [SUM_W-1:0]   chunk_sum;
  logic [ACC_W:0]     acc_wide;
  logic [ACC_W-1:0]   acc_add;
  logic               last_chunk;

  // The beat register shifts down one chunk per RUN cycle, so the low chunk is always current.
  adder_11to4 u_adder (
    .bits (beat[CHUNK_W-1:0]),
    .sum  (chunk_sum)
  );

  always_comb begin
    acc_wide   = {1'b0, acc} + {{(ACC_W+1-SUM_W){1'b0}}, chunk_sum};
    acc_add    = acc_wide[ACC_W] ? ACC_MAX : acc_wide[ACC_W-1:0];
    last_chunk = (chunk_idx == LAST_IDX);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) state_next = RUN;
        else          state_next = IDLE;
      end
      RUN: begin
        if (last_chunk) state_next = last_q ? DONE : IDLE;
        else            state_next = RUN;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
        else           state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_count <= '0;
      out_bit   <= 1'b0;
      out_sat   <= 1'b0;
      acc       <= '0;
      sat       <= 1'b0;
      first     <= 1'b1;
      beat      <= '0;
      last_q    <= 1'b0;
      chunk_idx <= '0;
      thresh_q  <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            beat      <= PAD_W'(in_data);
            last_q    <= in_last;
            chunk_idx <= '0;
            if (first) begin
              acc      <= '0;
              sat      <= 1'b0;
              thresh_q <= thresh;
              first    <= 1'b0;
            end
          end
        end
        RUN: begin
          acc       <= acc_add;
          sat       <= sat | acc_wide[ACC_W];
          beat      <= beat >> CHUNK_W;
          chunk_idx <= chunk_idx + IDX_W'(1);
          if (last_chunk && last_q) begin
            out_count <= acc_add;
            out_bit   <= (acc_add >= thresh_q);
            out_sat   <= sat | acc_wide[ACC_W];
          end
        end
        DONE: begin
          if (out_ready) begin
            first     <= 1'b1;
            out_count <= '0;
            out_bit   <= 1'b0;
            out_sat   <= 1'b0;
          end
        end
        default: begin
          first <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Scoreboard bench: two instances (16-bit and 8-bit accumulators) share one stimulus
// stream; a negedge monitor pops expected frame results whenever a result handshakes.
module tb_popcount_seq_ctrl;

  localparam int VEC_W = 99;

  logic             clk = 1'b0;
  logic             rst, clr, in_valid, in_last, out_ready;
  logic [VEC_W-1:0] in_data;
  logic [15:0]      thresh16;
  logic [7:0]       thresh8;
  logic             in_ready16, out_valid16, out_bit16, out_sat16, busy16;
  logic [15:0]      out_count16;
  logic             in_ready8, out_valid8, out_bit8, out_sat8, busy8;
  logic [7:0]       out_count8;

  typedef struct packed {
    logic [15:0] count;
    logic        bitv;
    logic        sat;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int   total = 0;
  int   bad = 0;
  int   model_cnt = 0;

  localparam logic [VEC_W-1:0] ONES = {VEC_W{1'b1}};

  always #5 clk = ~clk;

  popcount_seq_ctrl #(.VEC_W(VEC_W), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready16),
    .in_data(in_data), .in_last(in_last), .thresh(thresh16), .out_valid(out_valid16),
    .out_ready(out_ready), .out_count(out_count16), .out_bit(out_bit16),
    .out_sat(out_sat16), .busy(busy16)
  );

  popcount_seq_ctrl #(.VEC_W(VEC_W), .ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .in_last(in_last), .thresh(thresh8), .out_valid(out_valid8),
    .out_ready(out_ready), .out_count(out_count8), .out_bit(out_bit8),
    .out_sat(out_sat8), .busy(busy8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Saturating reference for both accumulator widths.
  task automatic push_expect();
    exp_t e;
    int   c;
    c       = (model_cnt > 65535) ? 65535 : model_cnt;
    e.count = c[15:0];
    e.sat   = (model_cnt > 65535);
    e.bitv  = (c >= int'(thresh16));
    q16.push_back(e);
    c       = (model_cnt > 255) ? 255 : model_cnt;
    e.count = c[15:0];
    e.sat   = (model_cnt > 255);
    e.bitv  = (c >= int'(thresh8));
    q8.push_back(e);
  endtask

  task automatic send_beat(input logic [VEC_W-1:0] data, input logic last);
    int n = 0;
    while (!(in_ready16 && in_ready8) && n < 200) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(n < 200), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_data  = ONES;
    in_last  = 1'b0;
    model_cnt += $countones(data);
    if (last) begin
      push_expect();
      model_cnt = 0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy16 || busy8 || q16.size() != 0 || q8.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check("drain", 32'(n < 200), 32'd1);
  endtask

  task automatic ready_low_cycles(input string name, input int req);
    int n = 0;
    while (!in_ready16 && n < 50) begin
      tick();
      n++;
    end
    check(name, n, req);
  endtask

  // Monitor: compare a result on the negedge before the edge that completes its handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_ready) begin
      if (out_valid16) begin
        if (q16.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out16 actual=%0d required=none", out_count16);
        end else begin
          e = q16.pop_front();
          check("count16", 32'(out_count16), 32'(e.count));
          check("bit16", 32'(out_bit16), 32'(e.bitv));
          check("sat16", 32'(out_sat16), 32'(e.sat));
        end
      end
      if (out_valid8) begin
        if (q8.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out8 actual=%0d required=none", out_count8);
        end else begin
          e = q8.pop_front();
          check("count8", 32'(out_count8), 32'(e.count));
          check("bit8", 32'(out_bit8), 32'(e.bitv));
          check("sat8", 32'(out_sat8), 32'(e.sat));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic [VEC_W-1:0] v;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_data = '0; thresh16 = 16'd50; thresh8 = 8'd50;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready16), 32'd1);
    check("rst_out_valid", 32'(out_valid16), 32'd0);
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_count8", 32'(out_count8), 32'd0);
    rst = 1'b0;
    tick();

    // 1: one all-ones beat; out_valid appears CHUNKS=9 edges after the accepting edge.
    send_beat(ONES, 1'b1);
    n = 0;
    while (!out_valid16 && n < 50) begin
      tick();
      n++;
    end
    check("t1_latency", n, 9);
    wait_drain();

    // 2: zero beat then bits 0,2; in_ready low 9 cycles after the first beat.
    thresh16 = 16'd3; thresh8 = 8'd3;
    send_beat('0, 1'b0);
    ready_low_cycles("t2_ready_low", 9);
    v = '0; v[0] = 1'b1; v[2] = 1'b1;
    send_beat(v, 1'b1);
    wait_drain();

    // Boundary patterns: count equal to threshold, chunk edges and top padded chunk.
    v = '0; v[10] = 1'b1; v[11] = 1'b1; v[98] = 1'b1;
    send_beat(v, 1'b1);
    wait_drain();

    // 3: four all-ones beats: 396 for 16-bit, clipped to 255 with sat for 8-bit.
    thresh16 = 16'd300; thresh8 = 8'd200;
    for (int i = 0; i < 4; i++) begin
      send_beat(ONES, 1'(i == 3));
      if (i < 3) ready_low_cycles("t3_ready_low", 9);
    end
    wait_drain();

    // 4: stall in DONE for 5 cycles.
    thresh16 = 16'd50; thresh8 = 8'd50;
    out_ready = 1'b0;
    send_beat(ONES, 1'b1);
    n = 0;
    while (!out_valid16 && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(out_valid16), 32'd1);
      check("t4_hold_count", 32'(out_count16), 32'd99);
      check("t4_hold_ready", 32'(in_ready16), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t4_ready_after", 32'(in_ready16), 32'd1);
    check("t4_valid_after", 32'(out_valid16), 32'd0);
    wait_drain();

    // 5: clr during RUN of a 2-beat frame drops the frame.
    send_beat(ONES, 1'b0);
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_cnt = 0;
    check("t5_busy", 32'(busy16), 32'd0);
    check("t5_in_ready", 32'(in_ready8), 32'd1);
    check("t5_out_valid", 32'(out_valid16), 32'd0);
    repeat (12) tick();
    send_beat(ONES, 1'b1);
    wait_drain();

    // 6: rst mid-RUN with in_valid high; the presented beat is not accepted.
    send_beat(ONES, 1'b1);
    repeat (2) tick();
    rst = 1'b1;
    in_valid = 1'b1; in_data = ONES; in_last = 1'b1;
    tick();
    check("t6_in_ready", 32'(in_ready16), 32'd1);
    check("t6_out_valid", 32'(out_valid16), 32'd0);
    check("t6_busy", 32'(busy8), 32'd0);
    check("t6_count", 32'(out_count16), 32'd0);
    check("t6_bit_sat", 32'({out_bit16, out_sat16}), 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    q16.delete(); q8.delete();
    model_cnt = 0;
    tick();
    check("t6_not_accepted", 32'(busy16), 32'd0);
    repeat (15) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
